// File: rtl/vga_scan_generator.sv
// VGA scan source: free-running h/v counters for the layer consumers, plus a timing
// delay line that re-aligns sync/blank with the colour returned COLOR_DELAY cycles later.
module vga_scan_generator #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int COLOR_DELAY = 7
) (
  input  logic               clk,
  input  logic               reset,
  output logic signed [31:0] count_h,
  output logic signed [31:0] count_v,
  output logic               frame_start,
  input  logic [7:0]         color_in,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               vga_de,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_DE_END     = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_DE_END     = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Timing bundle ordering is {de, hs, vs}; idle means blanked with both syncs released.
  localparam logic [2:0] TIMING_IDLE = 3'b011;

  logic [HW-1:0] hCount_q, hCount_d;
  logic [VW-1:0] vCount_q, vCount_d;
  logic [2:0]    timingRaw;
  logic [2:0]    timingDly;
  logic [2:0]    delay_q [COLOR_DELAY];
  logic          deOut_q, hsOut_q, vsOut_q;
  logic [11:0]   rgbOut_q, rgbOut_d;

  always_comb begin
    hCount_d = hCount_q + HW'(1);
    vCount_d = vCount_q;
    if (hCount_q == H_LAST) begin
      hCount_d = '0;
      vCount_d = (vCount_q == V_LAST) ? '0 : vCount_q + VW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hCount_q <= '0;
      vCount_q <= '0;
    end else begin
      hCount_q <= hCount_d;
      vCount_q <= vCount_d;
    end
  end

  assign timingRaw[2] = (hCount_q < H_DE_END) && (vCount_q < V_DE_END);
  assign timingRaw[1] = !((hCount_q >= H_SYNC_START) && (hCount_q < H_SYNC_END));
  assign timingRaw[0] = !((vCount_q >= V_SYNC_START) && (vCount_q < V_SYNC_END));

  // Matches the layer pipeline so timing and colour for the same pixel meet at the pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < COLOR_DELAY; i++) delay_q[i] <= TIMING_IDLE;
    end else begin
      delay_q[0] <= timingRaw;
      for (int i = 1; i < COLOR_DELAY; i++) delay_q[i] <= delay_q[i-1];
    end
  end

  assign timingDly = delay_q[COLOR_DELAY-1];

  always_comb begin
    rgbOut_d = '0;
    if (timingDly[2]) begin
      rgbOut_d = {color_in[7:5], color_in[7], color_in[4:2], color_in[4],
                  color_in[1:0], color_in[1:0]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deOut_q  <= 1'b0;
      hsOut_q  <= 1'b1;
      vsOut_q  <= 1'b1;
      rgbOut_q <= '0;
    end else begin
      deOut_q  <= timingDly[2];
      hsOut_q  <= timingDly[1];
      vsOut_q  <= timingDly[0];
      rgbOut_q <= rgbOut_d;
    end
  end

  assign count_h     = $signed({{(32-HW){1'b0}}, hCount_q});
  assign count_v     = $signed({{(32-VW){1'b0}}, vCount_q});
  assign frame_start = (hCount_q == '0) && (vCount_q == '0);
  assign vga_de      = deOut_q;
  assign vga_hs      = hsOut_q;
  assign vga_vs      = vsOut_q;
  assign vga_r       = rgbOut_q[11:8];
  assign vga_g       = rgbOut_q[7:4];
  assign vga_b       = rgbOut_q[3:0];

endmodule
